// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time on a valid/ready
// request channel, waits LATENCY cycles, commits to the backing array and
// returns read data / write acknowledge on a valid/ready response channel.
// Misaligned or out-of-window accesses complete with rsp_err=1 and no write.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  LAT_M1    = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
  localparam logic [31:0] DEPTH_W32 = 32'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;

  logic           cap_we;
  logic [31:0]    cap_addr;
  logic [31:0]    cap_wdata;
  logic [3:0]     cap_be;

  logic           op_we;
  logic [31:0]    op_addr;
  logic [31:0]    op_wdata;
  logic [3:0]     op_be;
  logic [31:0]    off;
  logic [AW-1:0]  idx;
  logic           err;

  logic           accept;
  logic           commit;
  logic           handshake;

  logic [31:0]    mem [DEPTH_WORDS];
  logic [31:0]    rdata_q;
  logic           err_q;

  // Replace the byte lanes selected by be with the new word's lanes.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // rst gates accept so a reset-held responder never commits a zero-latency write.
  assign accept    = rst && req_valid && (state_q == IDLE);
  assign handshake = (state_q == RESP) && rsp_ready;

  // With zero latency the commit happens on the accept edge, before the
  // capture registers hold the request, so the live request is used then.
  always_comb begin
    if (state_q == IDLE) begin
      op_we    = req_we;
      op_addr  = req_addr;
      op_wdata = req_wdata;
      op_be    = req_be;
    end else begin
      op_we    = cap_we;
      op_addr  = cap_addr;
      op_wdata = cap_wdata;
      op_be    = cap_be;
    end
  end

  // Address decode: BASE_ADDR is word aligned, so off[1:0] equals the address
  // low bits; an address below the base wraps to a huge offset and fails the range test.
  always_comb begin
    off = op_addr - BASE_ADDR;
    idx = off[AW+1:2];
    err = (off[1:0] != 2'b00) || ({2'b00, off[31:2]} >= DEPTH_W32);
  end

  assign commit = rst && ((accept && (LATENCY == 0)) ||
                          ((state_q == WAIT) && (cnt_q == 4'd0)));

  // State and wait-counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: IDLE -> (WAIT ->) RESP -> IDLE on handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Hold the accepted request; later changes on req_* are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_we    <= req_we;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
      cap_be    <= req_be;
    end
  end

  // Backing array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit && op_we && !err) begin
      mem[idx] <= merge_bytes(mem[idx], op_wdata, op_be);
    end
  end

  // Response payload: loaded on the edge entering RESP, held until the
  // handshake, then cleared back to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (commit) begin
      rdata_q <= (op_we || err) ? 32'd0 : mem[idx];
      err_q   <= err;
    end else if (handshake) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two builds (LATENCY=2 at base 0, LATENCY=0 at a
// non-zero base with a small window), directed scenarios plus random traffic
// checked against a word-addressed reference memory.
module tb_dmem_responder;

  localparam int          DEPTH0 = 1024;
  localparam int          LAT0   = 2;
  localparam logic [31:0] BASE0  = 32'h0000_0000;
  localparam int          DEPTH1 = 16;
  localparam int          LAT1   = 0;
  localparam logic [31:0] BASE1  = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [1:0]        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err, busy;
  logic [1:0][31:0]  req_addr, req_wdata, rsp_rdata;
  logic [1:0][3:0]   req_be;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [31:0] mdl [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_WORDS(DEPTH0), .LATENCY(LAT0), .BASE_ADDR(BASE0)) u0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH1), .LATENCY(LAT1), .BASE_ADDR(BASE1)) u1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  function automatic int lat_of(input int u);
    return (u == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [31:0] base_of(input int u);
    return (u == 0) ? BASE0 : BASE1;
  endfunction

  function automatic int depth_of(input int u);
    return (u == 0) ? DEPTH0 : DEPTH1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Reference: byte-offset window check, word memory keyed by unit and word number.
  task automatic model(input int u, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       output logic [31:0] rd, output logic er);
    logic [31:0] off;
    logic [31:0] w;
    int          k;
    off = addr - base_of(u);
    er  = (addr % 4 != 0) || (off >= 32'(depth_of(u) * 4));
    rd  = 32'd0;
    if (!er) begin
      k = u * (1 << 20) + int'(off / 4);
      w = mdl.exists(k) ? mdl[k] : 32'd0;
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
        mdl[k] = w;
      end else begin
        rd = w;
      end
    end
  endtask

  // One complete transaction with latency, hold and post-handshake checks.
  task automatic txn(input int u, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int hold,
                     output logic [31:0] rd_obs, output int acc_cyc);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          n;
    model(u, we, addr, wdata, be, exp_rd, exp_err);
    rd_obs = 32'hFFFF_FFFF;
    check($sformatf("u%0d req_ready_idle", u), 32'(req_ready[u]), 32'd1);
    req_valid[u] = 1'b1;
    req_we[u]    = we;
    req_addr[u]  = addr;
    req_wdata[u] = wdata;
    req_be[u]    = be;
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid[u] = 1'($urandom);
    req_we[u]    = 1'($urandom);
    req_addr[u]  = $urandom;
    req_wdata[u] = $urandom;
    req_be[u]    = 4'($urandom);
    n = 1;
    while (!rsp_valid[u] && n < 40) begin
      check($sformatf("u%0d busy_wait", u), 32'(busy[u]), 32'd1);
      check($sformatf("u%0d req_ready_wait", u), 32'(req_ready[u]), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("u%0d latency", u), 32'(n), 32'(lat_of(u) + 1));
    if (rsp_valid[u]) begin
      rd_obs = rsp_rdata[u];
      for (int k = 0; k <= hold; k++) begin
        check($sformatf("u%0d rsp_valid", u), 32'(rsp_valid[u]), 32'd1);
        check($sformatf("u%0d rsp_rdata", u), rsp_rdata[u], exp_rd);
        check($sformatf("u%0d rsp_err", u), 32'(rsp_err[u]), 32'(exp_err));
        check($sformatf("u%0d busy_resp", u), 32'(busy[u]), 32'd1);
        check($sformatf("u%0d req_ready_resp", u), 32'(req_ready[u]), 32'd0);
        if (k == hold) rsp_ready[u] = 1'b1;
        @(posedge clk); #1;
      end
      rsp_ready[u] = 1'b0;
      req_valid[u] = 1'b0;
      check($sformatf("u%0d rsp_valid_after", u), 32'(rsp_valid[u]), 32'd0);
      check($sformatf("u%0d rdata_after", u), rsp_rdata[u], 32'd0);
      check($sformatf("u%0d err_after", u), 32'(rsp_err[u]), 32'd0);
      check($sformatf("u%0d req_ready_after", u), 32'(req_ready[u]), 32'd1);
      check($sformatf("u%0d busy_after", u), 32'(busy[u]), 32'd0);
    end
    req_valid[u] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int          ac;
    int          prev_ac;
    int          u;
    int          sel;
    logic [31:0] a;
    logic [31:0] saved30;

    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d rst_rsp_valid", i), 32'(rsp_valid[i]), 32'd0);
      check($sformatf("u%0d rst_busy", i), 32'(busy[i]), 32'd0);
      check($sformatf("u%0d rst_rdata", i), rsp_rdata[i], 32'd0);
      check($sformatf("u%0d rst_err", i), 32'(rsp_err[i]), 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("u0 ready_after_rst", 32'(req_ready[0]), 32'd1);
    check("u1 ready_after_rst", 32'(req_ready[1]), 32'd1);

    // Directed first store (LATENCY=2 timing)
    txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd, ac);
    check("store_rdata_zero", rd, 32'd0);

    // Known contents for the words used below
    for (int w = 0; w < 16; w++) begin
      if (w != 4) txn(0, 1'b1, BASE0 + 32'(4 * w), $urandom, 4'hF, 0, rd, ac);
      txn(1, 1'b1, BASE1 + 32'(4 * w), $urandom, 4'hF, 0, rd, ac);
    end

    // Byte-lane store
    txn(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 0, rd, ac);
    txn(0, 1'b1, 32'h20, 32'h0000_00AA, 4'b0001, 0, rd, ac);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, ac);
    check("byte_lane_word", rd, 32'h1122_33AA);

    // Zero-enable store is a legal no-op
    txn(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 0, rd, ac);
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, rd, ac);
    check("be_zero_noop", rd, 32'h1122_33AA);

    // Backpressure hold for 5 cycles
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, rd, ac);
    check("backpressure_word", rd, 32'hDEAD_BEEF);

    // Errors: misaligned load, out-of-range store, contents unchanged
    txn(0, 1'b0, 32'h13, 32'h0, 4'h0, 0, rd, ac);
    txn(0, 1'b1, 32'h1000, 32'h5555_5555, 4'hF, 0, rd, ac);
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, rd, ac);

    // Reset during WAIT drops the store
    txn(0, 1'b0, 32'h30, 32'h0, 4'h0, 0, saved30, ac);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h30;
    req_wdata[0] = 32'hCAFE_F00D; req_be[0] = 4'hF;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("midrst_busy_before", 32'(busy[0]), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("midrst_busy", 32'(busy[0]), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    txn(0, 1'b0, 32'h30, 32'h0, 4'h0, 0, rd, ac);
    check("midrst_no_commit", rd, saved30);

    // LATENCY=0 unit: window edges and back-to-back stream
    txn(1, 1'b0, BASE1 - 32'd4, 32'h0, 4'h0, 0, rd, ac);
    txn(1, 1'b0, BASE1 + 32'(4 * DEPTH1), 32'h0, 4'h0, 0, rd, ac);
    txn(1, 1'b0, BASE1 + 32'(4 * DEPTH1 - 4), 32'h0, 4'h0, 0, rd, ac);
    txn(1, 1'b0, BASE1, 32'h0, 4'h0, 0, rd, prev_ac);
    for (int i = 1; i < 6; i++) begin
      txn(1, 1'b0, BASE1 + 32'(4 * i), 32'h0, 4'h0, 0, rd, ac);
      check("lat0_spacing", 32'(ac - prev_ac), 32'd2);
      prev_ac = ac;
    end

    // Random traffic on both units
    for (int t = 0; t < 120; t++) begin
      u   = t % 2;
      sel = $urandom_range(0, 9);
      if (sel < 7)
        a = base_of(u) + 32'(4 * $urandom_range(0, 15));
      else if (sel < 8)
        a = base_of(u) + 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
      else if (sel < 9)
        a = base_of(u) + 32'(4 * depth_of(u)) + 32'(4 * $urandom_range(0, 255));
      else
        a = base_of(u) - 32'(4 * $urandom_range(1, 8));
      txn(u, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom),
          $urandom_range(0, 3), rd, ac);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
